// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the instruction-memory read port, the branch redirect input and
//   the decoder-facing valid/ready handshake of the instruction fetch unit.
//
//   master : the fetch unit (drives mem request, owns the decoder output)
//   slave  : the environment (memory returning data, branch unit, decoder)
//
//   mem_enable     read request to instruction memory this cycle
//   mem_addr       byte address of the request
//   mem_data       read data, valid one cycle after mem_enable
//   redirect_valid branch/jump taken: flush and refetch from redirect_addr
//   redirect_addr  new fetch PC
//   out_valid      fetched word available at FIFO head
//   out_ready      decoder accepts the head word this cycle
//   out_pc         address the head word was fetched from
//   out_instr      head word
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 48
);
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;

  modport master (
    output mem_enable,
    output mem_addr,
    input  mem_data,
    input  redirect_valid,
    input  redirect_addr,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  mem_enable,
    input  mem_addr,
    output mem_data,
    output redirect_valid,
    output redirect_addr,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Reader side of the fixed-latency instruction RAM. Issues fetch requests
//   at fetch_pc, captures the returned word one cycle later together with its
//   PC, buffers it in a small prefetch FIFO and presents the FIFO head to the
//   decoder over valid/ready. A branch redirect flushes the FIFO, drops the
//   response in flight and restarts fetching at the redirect address.
//
//   clk  system clock, all state updates on posedge
//   rst  synchronous reset, active-high; overrides redirect and handshake
//   bus  instr_fetch_unit_if.master (memory port, redirect, decoder output)
//
//   No FSM: state is fetch_pc, a one-bit in-flight flag with the PC of the
//   outstanding request, and the FIFO pointers/count.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 48,
  parameter int                    STRIDE     = DATA_WIDTH / 8,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                  clk,
  input logic                  rst,
  instr_fetch_unit_if.master   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic                  out_valid;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CW:0]           credit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    out_valid = !rst && (count != '0);
    pop       = out_valid && bus.out_ready;
    // The response arriving in a redirect cycle belongs to the old stream.
    push      = inflight && !bus.redirect_valid;
    // Credit counts buffered words plus the outstanding request; a word
    // leaving this cycle frees its slot for a new request immediately, which
    // is what gives one word per cycle with the minimum two-entry FIFO.
    credit    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue     = !rst && !bus.redirect_valid && (credit < (CW+1)'(DEPTH));
  end

  assign bus.mem_enable = issue;
  assign bus.mem_addr   = fetch_pc;
  assign bus.out_valid  = out_valid;
  assign bus.out_pc     = pc_mem[rd_ptr];
  assign bus.out_instr  = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_addr;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(STRIDE);
        if (push)  wr_ptr   <= next_ptr(wr_ptr);
        if (pop)   rd_ptr   <= next_ptr(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Datapath registers carry no reset: their contents are only observed
  // through out_valid/count and inflight, which are reset.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc <= fetch_pc;
    if (push && !rst) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= bus.mem_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRIDE(6), .DEPTH(2), .RESET_PC('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic [31:0] e;

  // 256-byte memory where byte i holds i; 6 bytes big-endian per word.
  function automatic logic [47:0] mem_word(input logic [31:0] a);
    logic [47:0] w;
    logic [7:0]  b;
    w = '0;
    for (int i = 0; i < 6; i++) begin
      b = a[7:0] + 8'(i);
      w = {w[39:0], b};
    end
    return w;
  endfunction

  always @(posedge clk)
    if (bus.mem_enable) bus.mem_data <= mem_word(bus.mem_addr);

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd6;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_addr = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mem_enable: got %b want 0", bus.mem_enable); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    end
    @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
    exp_q.delete(); next_pc = '0; push_exp(4); #1;
    n_checks++; if (bus.mem_enable !== 1'b1) begin n_fail++; $display("FAIL rel_mem_enable: got %b want 1", bus.mem_enable); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rel_mem_addr: got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid_r: got %b want 0", bus.out_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid_r1: got %b want 0", bus.out_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rel_stream_valid: cycle %0d got %b want 1", k, bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rel_extra: unexpected pc %h", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e) begin n_fail++; $display("FAIL rel_pc: got %h want %h", bus.out_pc, e); end
          n_checks++; if (bus.out_instr !== mem_word(e)) begin n_fail++; $display("FAIL rel_instr: got %h want %h", bus.out_instr, mem_word(e)); end
        end
      end
    end
  endtask

  task automatic test_stall;
    push_exp(5);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); bus.out_ready = 1'b0; #1;
      if (c >= 1) begin
        n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL stall_mem_enable: cycle %0d got %b want 0", c, bus.mem_enable); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_pc !== exp_q[0]) begin n_fail++; $display("FAIL stall_pc: got %h want %h", bus.out_pc, exp_q[0]); end
        n_checks++; if (bus.out_instr !== mem_word(exp_q[0])) begin n_fail++; $display("FAIL stall_instr: got %h want %h", bus.out_instr, mem_word(exp_q[0])); end
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); bus.out_ready = 1'b1; #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid: cycle %0d got %b want 1", c, bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL resume_extra: unexpected pc %h", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e) begin n_fail++; $display("FAIL resume_pc: got %h want %h", bus.out_pc, e); end
          n_checks++; if (bus.out_instr !== mem_word(e)) begin n_fail++; $display("FAIL resume_instr: got %h want %h", bus.out_instr, mem_word(e)); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL resume_left: got %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_full;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.out_ready = 1'b0; #1;
      n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL fill_mem_enable: got %b want 0", bus.mem_enable); end
    end
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h40; #1;
    n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL redir_mem_enable: got %b want 0", bus.mem_enable); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_full_valid: got %b want 1", bus.out_valid); end
    exp_q.delete(); next_pc = 32'h40; push_exp(2);
    @(negedge clk); bus.redirect_valid = 1'b0; bus.out_ready = 1'b1; #1;
    n_checks++; if (bus.mem_enable !== 1'b1) begin n_fail++; $display("FAIL redir_issue: got %b want 1", bus.mem_enable); end
    n_checks++; if (bus.mem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %h want 40", bus.mem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_t1: got %b want 0", bus.out_valid); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_t2: got %b want 0", bus.out_valid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid_t3: cycle %0d got %b want 1", c, bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL redir_extra: unexpected pc %h", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e) begin n_fail++; $display("FAIL redir_pc: got %h want %h", bus.out_pc, e); end
          n_checks++; if (bus.out_instr !== mem_word(e)) begin n_fail++; $display("FAIL redir_instr: got %h want %h", bus.out_instr, mem_word(e)); end
        end
      end
    end
  endtask

  task automatic test_wrap;
    @(negedge clk); bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_addr = 32'hFFFF_FFFC; #1;
    exp_q.delete(); next_pc = 32'hFFFF_FFFC; push_exp(3);
    @(negedge clk); bus.redirect_valid = 1'b0; bus.out_ready = 1'b1; #1;
    n_checks++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", bus.mem_addr); end
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      @(negedge clk); #1;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (bus.out_pc !== e) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", bus.out_pc, e); end
        n_checks++; if (bus.out_instr !== mem_word(e)) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", bus.out_instr, mem_word(e)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_timeout: got %0d words pending want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_inflight;
    push_exp(3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); bus.out_ready = 1'b1;
      if (c == 2) begin bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h80; end
      #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL infl_valid: cycle %0d got %b want 1", c, bus.out_valid); end
      n_checks++; if (bus.mem_enable !== (c != 2)) begin n_fail++; $display("FAIL infl_mem_enable: cycle %0d got %b want %b", c, bus.mem_enable, c != 2); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL infl_extra: unexpected pc %h", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e) begin n_fail++; $display("FAIL infl_pc: got %h want %h", bus.out_pc, e); end
        end
      end
    end
    exp_q.delete(); next_pc = 32'h80; push_exp(2);
    @(negedge clk); bus.redirect_valid = 1'b0; #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL infl_stale_t1: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.mem_addr !== 32'h80) begin n_fail++; $display("FAIL infl_addr: got %h want 80", bus.mem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL infl_stale_t2: got %b want 0", bus.out_valid); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL infl_new_valid: got %b want 1", bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (bus.out_pc !== e) begin n_fail++; $display("FAIL infl_new_pc: got %h want %h", bus.out_pc, e); end
        n_checks++; if (bus.out_instr !== mem_word(e)) begin n_fail++; $display("FAIL infl_new_instr: got %h want %h", bus.out_instr, mem_word(e)); end
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_addr = 32'h10; #1;
    n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_enable0: got %b want 0", bus.mem_enable); end
    @(negedge clk); bus.redirect_addr = 32'h20; #1;
    n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_enable1: got %b want 0", bus.mem_enable); end
    exp_q.delete(); next_pc = 32'h20; push_exp(2);
    @(negedge clk); bus.redirect_valid = 1'b0; bus.out_ready = 1'b1; #1;
    n_checks++; if (bus.mem_addr !== 32'h20) begin n_fail++; $display("FAIL b2b_addr: got %h want 20", bus.mem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b want 0", bus.out_valid); end
    @(negedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid: got %b want 1", bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (bus.out_pc !== e) begin n_fail++; $display("FAIL b2b_pc: got %h want %h", bus.out_pc, e); end
      end
    end
  endtask

  task automatic test_reset_mid;
    push_exp(1);
    @(negedge clk); bus.out_ready = 1'b1; #1;
    if (bus.out_valid && bus.out_ready) begin
      n_checks++;
      e = exp_q.pop_front();
      if (bus.out_pc !== e) begin n_fail++; $display("FAIL mid_pre_pc: got %h want %h", bus.out_pc, e); end
    end
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (bus.mem_enable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mem_enable: got %b want 0", bus.mem_enable); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    exp_q.delete(); next_pc = '0; push_exp(3);
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_r: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.mem_enable !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_issue: got en=%b addr=%h want en=1 addr=0", bus.mem_enable, bus.mem_addr); end
    @(negedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_r1: got %b want 0", bus.out_valid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_stream_valid: cycle %0d got %b want 1", c, bus.out_valid); end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (bus.out_pc !== e) begin n_fail++; $display("FAIL mid_pc: got %h want %h", bus.out_pc, e); end
        n_checks++; if (bus.out_instr !== mem_word(e)) begin n_fail++; $display("FAIL mid_instr: got %h want %h", bus.out_instr, mem_word(e)); end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_left: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_redirect_inflight();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk); bus.out_ready = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
